div_unit: RTL and testbench

Sequential signed 32-bit divider that feeds the HI/LO registers through the HI/LO source muxes (div_hi_out -> HI, div_lo_out -> LO).
- Operands come from the A and B registers.
- The control unit starts it with div_start and waits on div_done before writing HI/LO.
- Raises div_zero on divide-by-zero so the control unit can take the exception path (EPC write, exception vector).
- Implements the MIPS DIV instruction: quotient to LO, remainder to HI.

---
 rtl/div_pkg.sv | 15 +
 rtl/div_if.sv | 32 +++
 rtl/div_abs.sv | 16 +
 rtl/div_unit.sv | 146 ++++++++++++++
 tb/tb_div_unit.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared constants for the sequential signed divider.
//   DIV_WIDTH  - operand/result width (32 is the only width this CPU uses)
//   DIV_CNT_W  - iteration counter width, wide enough to hold DIV_WIDTH-1
//   ST_*       - divider FSM state encoding
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/div_if.sv
// div_if: handshake and data bundle between the control unit and the divider.
//   div_start  - one-cycle start pulse (control unit -> divider)
//   dividend   - signed dividend, A register
//   divisor    - signed divisor, B register
//   div_hi_out - remainder, feeds the HI mux
//   div_lo_out - quotient, feeds the LO mux
//   div_busy   - division in progress
//   div_done   - one-cycle pulse, results valid
//   div_zero   - one-cycle pulse with div_done on divide-by-zero
// Modports: master = control unit side, slave = divider side.
interface div_if import div_pkg::*; #(parameter int WIDTH = DIV_WIDTH);

  logic             div_start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] div_hi_out;
  logic [WIDTH-1:0] div_lo_out;
  logic             div_busy;
  logic             div_done;
  logic             div_zero;

  modport master (
    output div_start, dividend, divisor,
    input  div_hi_out, div_lo_out, div_busy, div_done, div_zero
  );

  modport slave (
    input  div_start, dividend, divisor,
    output div_hi_out, div_lo_out, div_busy, div_done, div_zero
  );

endinterface

// File: rtl/div_abs.sv
// div_abs: conditional two's-complement negate.
//   in_val  - input value
//   neg     - when high, out_val = -in_val; otherwise out_val = in_val
//   out_val - result
// Used both for operand magnitudes and for re-applying result signs.
module div_abs import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] in_val,
  input  logic             neg,
  output logic [WIDTH-1:0] out_val
);

  assign out_val = neg ? ((~in_val) + WIDTH'(1)) : in_val;

endmodule

// File: rtl/div_unit.sv
// div_unit: sequential signed divider for MIPS DIV (quotient -> LO,
// remainder -> HI). Restoring division on magnitudes, one quotient bit per
// clock, followed by a sign fix-up cycle.
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - div_if.slave: start/operands in, results/status out
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | waiting for div_start; results held
// CALC    | WIDTH restoring-division iterations on magnitudes
// FIX     | apply signs, register quotient/remainder
// DONE    | div_done pulse (plus div_zero on divide-by-zero)
module div_unit import div_pkg::*; #(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic clk,
  input  logic reset,
  div_if.slave bus
);

  localparam logic [DIV_CNT_W-1:0] LAST_ITER = DIV_CNT_W'(WIDTH - 1);

  logic [1:0]           state;
  logic [DIV_CNT_W-1:0] iter;
  logic                 sign_dvd;
  logic                 sign_dvs;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     dvs;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 done_q;
  logic                 zero_q;

  logic [WIDTH-1:0]     dvd_mag;
  logic [WIDTH-1:0]     dvs_mag;
  logic [WIDTH-1:0]     quo_fix;
  logic [WIDTH-1:0]     rem_fix;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       trial;
  logic                 divisor_zero;

  div_abs #(.WIDTH(WIDTH)) u_abs_dvd (
    .in_val (bus.dividend),
    .neg    (bus.dividend[WIDTH-1]),
    .out_val(dvd_mag)
  );

  div_abs #(.WIDTH(WIDTH)) u_abs_dvs (
    .in_val (bus.divisor),
    .neg    (bus.divisor[WIDTH-1]),
    .out_val(dvs_mag)
  );

  div_abs #(.WIDTH(WIDTH)) u_fix_quo (
    .in_val (quo),
    .neg    (sign_dvd ^ sign_dvs),
    .out_val(quo_fix)
  );

  div_abs #(.WIDTH(WIDTH)) u_fix_rem (
    .in_val (rem),
    .neg    (sign_dvd),
    .out_val(rem_fix)
  );

  assign divisor_zero = (bus.divisor == '0);

  // The extra top bit keeps the compare correct when |divisor| is 2^(WIDTH-1);
  // the borrow out of bit WIDTH marks a negative trial.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      iter     <= '0;
      sign_dvd <= 1'b0;
      sign_dvs <= 1'b0;
      quo      <= '0;
      rem      <= '0;
      dvs      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      zero_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.div_start) begin
            if (divisor_zero) begin
              // Results are left untouched so HI/LO keep their old values.
              done_q <= 1'b1;
              zero_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              sign_dvd <= bus.dividend[WIDTH-1];
              sign_dvs <= bus.divisor[WIDTH-1];
              quo      <= dvd_mag;
              dvs      <= dvs_mag;
              rem      <= '0;
              iter     <= '0;
              state    <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= rem_shift[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          if (iter == LAST_ITER) begin
            state <= ST_FIX;
          end else begin
            iter <= iter + DIV_CNT_W'(1);
          end
        end
        ST_FIX: begin
          lo_q   <= quo_fix;
          hi_q   <= rem_fix;
          done_q <= 1'b1;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.div_hi_out = hi_q;
  assign bus.div_lo_out = lo_q;
  assign bus.div_busy   = (state != ST_IDLE);
  assign bus.div_done   = done_q;
  assign bus.div_zero   = zero_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit. Directed vector table,
// hand-written multi-cycle sequences, and random operands checked against
// a plain-arithmetic reference model.
module tb_div_unit;

  logic clk;
  logic reset;

  div_if #(.WIDTH(32)) bus ();

  div_unit dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] exp_lo;
    logic [31:0] exp_hi;
    logic        exp_zero;
  } vec_t;

  vec_t vecs[$];

  // Model state: last results the divider should be presenting.
  logic [31:0] model_lo;
  logic [31:0] model_hi;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Truncating signed division on 64-bit integers, then cut to 32 bits.
  // Using longint keeps the 0x80000000 / -1 overflow case well defined.
  task automatic model_div(input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lq = sa / sb;
    lr = sa - lq * sb;
    q  = lq[31:0];
    r  = lr[31:0];
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.div_start = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_lo = '0;
    model_hi = '0;
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    bus.dividend  = a;
    bus.divisor   = b;
    bus.div_start = 1'b1;
    @(posedge clk); #1;
    bus.div_start = 1'b0;
  endtask

  // lat counts edges from the start-sampling edge (inclusive) until div_done is seen.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!bus.div_done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // Full operation with protocol and result checks.
  task automatic run_and_check(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                               input logic exp_zero);
    int lat;
    start_op(a, b);
    check({tag, ".busy_after_start"}, 32'(bus.div_busy), 32'd1);
    wait_done(lat);
    check({tag, ".latency"}, 32'(lat), exp_zero ? 32'd1 : 32'd34);
    check({tag, ".lo"}, bus.div_lo_out, exp_lo);
    check({tag, ".hi"}, bus.div_hi_out, exp_hi);
    check({tag, ".zero"}, 32'(bus.div_zero), 32'(exp_zero));
    @(posedge clk); #1;
    check({tag, ".done_pulse"}, 32'(bus.div_done), 32'd0);
    check({tag, ".zero_pulse"}, 32'(bus.div_zero), 32'd0);
    check({tag, ".busy_after"}, 32'(bus.div_busy), 32'd0);
  endtask

  initial begin
    int lat;
    int extra_done;
    logic [31:0] a, b, q, r;

    vecs.push_back('{32'd7,          32'd2,          32'h00000003, 32'h00000001, 1'b0});
    vecs.push_back('{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 1'b0});
    vecs.push_back('{32'hFFFFFFF9,   32'hFFFFFFFE,   32'h00000003, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 1'b0});
    vecs.push_back('{32'h80000000,   32'd1,          32'h80000000, 32'h00000000, 1'b0});
    vecs.push_back('{32'h80000000,   32'h80000000,   32'h00000001, 32'h00000000, 1'b0});
    vecs.push_back('{32'hFFFFFFFF,   32'h80000000,   32'h00000000, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{32'd7,          32'd2,          32'h00000003, 32'h00000001, 1'b0});
    vecs.push_back('{32'd5,          32'd0,          32'h00000003, 32'h00000001, 1'b1});
    vecs.push_back('{32'd0,          32'd5,          32'h00000000, 32'h00000000, 1'b0});
    vecs.push_back('{32'h7FFFFFFF,   32'h7FFFFFFF,   32'h00000001, 32'h00000000, 1'b0});
    vecs.push_back('{32'h7FFFFFFF,   32'd0,          32'h00000001, 32'h00000000, 1'b1});

    do_reset();
    check("reset.lo",   bus.div_lo_out, 32'd0);
    check("reset.hi",   bus.div_hi_out, 32'd0);
    check("reset.busy", 32'(bus.div_busy), 32'd0);
    check("reset.done", 32'(bus.div_done), 32'd0);
    check("reset.zero", 32'(bus.div_zero), 32'd0);

    foreach (vecs[i]) begin
      run_and_check($sformatf("vec%0d", i), vecs[i].dividend, vecs[i].divisor,
                    vecs[i].exp_lo, vecs[i].exp_hi, vecs[i].exp_zero);
    end

    // Operand changes and a start pulse mid-division must not disturb it.
    start_op(32'd100, 32'd7);
    lat = 1;
    while (!bus.div_done && lat < 100) begin
      if (lat == 5) begin
        bus.dividend  = 32'd55;
        bus.divisor   = 32'd3;
        bus.div_start = 1'b1;
      end else begin
        bus.div_start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    bus.div_start = 1'b0;
    check("busy_start.latency", 32'(lat), 32'd34);
    check("busy_start.lo", bus.div_lo_out, 32'd14);
    check("busy_start.hi", bus.div_hi_out, 32'd2);
    extra_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.div_done) extra_done++;
    end
    check("busy_start.no_second_done", 32'(extra_done), 32'd0);
    check("hold.lo", bus.div_lo_out, 32'd14);
    check("hold.hi", bus.div_hi_out, 32'd2);

    // A start arriving in the DONE cycle is ignored.
    start_op(32'd50, 32'd6);
    wait_done(lat);
    check("done_start.latency", 32'(lat), 32'd34);
    bus.dividend  = 32'd9;
    bus.divisor   = 32'd2;
    bus.div_start = 1'b1;
    @(posedge clk); #1;
    bus.div_start = 1'b0;
    check("done_start.busy", 32'(bus.div_busy), 32'd0);
    check("done_start.lo", bus.div_lo_out, 32'd8);
    check("done_start.hi", bus.div_hi_out, 32'd2);

    // Reset mid-division abandons the operation.
    start_op(32'd100, 32'd7);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_reset.lo",   bus.div_lo_out, 32'd0);
    check("mid_reset.hi",   bus.div_hi_out, 32'd0);
    check("mid_reset.busy", 32'(bus.div_busy), 32'd0);
    check("mid_reset.done", 32'(bus.div_done), 32'd0);
    run_and_check("after_reset", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    model_lo = 32'd3;
    model_hi = 32'd0;

    // Random operands against the arithmetic model.
    for (int n = 0; n < 40; n++) begin
      a = $urandom();
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 15);
        2:       b = -($urandom_range(1, 15));
        default: b = $urandom();
      endcase
      if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 1000);
      if (b != 0) begin
        model_div(a, b, q, r);
        model_lo = q;
        model_hi = r;
      end
      run_and_check($sformatf("rand%0d", n), a, b, model_lo, model_hi, b == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
